demux_4x_nbit_hs: RTL and testbench

- 1-to-4 demultiplexer with valid/ready handshakes. It is the distribution-side counterpart of the team's 4:1 n-bit select mux.
- Steers each input word to one of four output channels, chosen by a 2-bit select.
- Each channel has a single-entry output register, so a stalled consumer blocks only traffic addressed to it.
- Sits between a single producer and four independent consumers in the datapath.

---
 rtl/demux_4x_nbit_hs.sv | 81 ++++++++
 tb/tb_demux_4x_nbit_hs.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_4x_nbit_hs.sv
// 1-to-4 valid/ready demultiplexer with a single-entry output register per channel.
// Optional macro DEMUX_RR_EN: the target comes from a round-robin pointer instead of in_sel.
module demux_4x_nbit_hs #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic [1:0]           in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BUS_WIDTH-1:0] out_a,
  output logic [BUS_WIDTH-1:0] out_b,
  output logic [BUS_WIDTH-1:0] out_c,
  output logic [BUS_WIDTH-1:0] out_d,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready
);

  logic [BUS_WIDTH-1:0] r_data [4];
  logic [3:0]           r_valid;
  logic [1:0]           w_tgt;
  logic                 w_accept;
  logic [3:0]           w_load;

`ifdef DEMUX_RR_EN
  logic [1:0] r_ptr;

  // Strict ordering: the pointer moves only on an accepted word, so a full target stalls the input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= 2'd0;
    end else if (w_accept) begin
      r_ptr <= r_ptr + 2'd1;
    end
  end

  assign w_tgt = r_ptr;
`else
  assign w_tgt = in_sel;
`endif

  // A full channel can still accept when its consumer drains at the same edge.
  assign in_ready = ~r_valid[w_tgt] | out_ready[w_tgt];
  assign w_accept = in_valid & in_ready;

  always_comb begin
    // NOTE: default assignment first so no path through this block can infer a latch.
    w_load = 4'b0000;
    if (w_accept) begin
      w_load[w_tgt] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 4'b0000;
      // NOTE: the data registers are cleared too, because out_x must read 0 straight after reset.
      for (int k = 0; k < 4; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        // NOTE: non-blocking assignments keep every channel update order-independent within the edge.
        if (w_load[k]) begin
          r_data[k]  <= in_data;
          r_valid[k] <= 1'b1;
        end else if (out_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign out_a     = r_data[0];
  assign out_b     = r_data[1];
  assign out_c     = r_data[2];
  assign out_d     = r_data[3];
  assign out_valid = r_valid;

endmodule

// File: tb/tb_demux_4x_nbit_hs.sv
// Self-checking bench for demux_4x_nbit_hs: vector table plus a per-channel drain scoreboard.
// The DEMUX_RR_EN build runs the round-robin table instead of the in_sel table.
module tb_demux_4x_nbit_hs;

  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic [1:0]    in_sel = 2'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] out_a, out_b, out_c, out_d;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready = 4'b0000;

  demux_4x_nbit_hs #(.BUS_WIDTH(BW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] out_of(input int k);
    case (k)
      0:       return out_a;
      1:       return out_b;
      2:       return out_c;
      default: return out_d;
    endcase
  endfunction

  // Scoreboard: accepted words are queued with their expected channel and compared on drain.
  typedef struct {
    logic [1:0]    ch;
    logic [BW-1:0] data;
  } sb_t;

  sb_t        sb[$];
  logic [1:0] m_ptr = 2'd0;

  always @(posedge clk) begin
    int   idx;
    logic found;
    logic [1:0] tgt;
    if (!rst_n) begin
      sb.delete();
      m_ptr = 2'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          idx = -1;
          for (int j = 0; j < sb.size(); j++) begin
            if (idx < 0 && sb[j].ch == 2'(k)) idx = j;
          end
          found = (idx >= 0);
          check($sformatf("sb_pending_ch%0d", k), 32'(found), 32'd1);
          if (found) begin
            check($sformatf("sb_data_ch%0d", k), 32'(out_of(k)), 32'(sb[idx].data));
            sb.delete(idx);
          end
        end
      end
`ifdef DEMUX_RR_EN
      tgt = m_ptr;
`else
      tgt = in_sel;
`endif
      if (in_valid && in_ready) begin
        sb.push_back('{tgt, in_data});
        m_ptr = m_ptr + 2'd1;
      end
    end
  end

  typedef struct {
    logic          rst;
    logic          valid;
    logic [1:0]    sel;
    logic [BW-1:0] data;
    logic [3:0]    ordy;
    logic          exp_rdy;
    logic [3:0]    exp_ov;
    logic          chk;
    logic [1:0]    chk_ch;
    logic [BW-1:0] chk_data;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic valid, input logic [1:0] sel,
                     input logic [BW-1:0] data, input logic [3:0] ordy, input logic exp_rdy,
                     input logic [3:0] exp_ov, input logic chk, input logic [1:0] chk_ch,
                     input logic [BW-1:0] chk_data);
    vecs.push_back('{rst, valid, sel, data, ordy, exp_rdy, exp_ov, chk, chk_ch, chk_data});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_two, exp_one;

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    for (int k = 0; k < 4; k++) check($sformatf("rst_out%0d", k), 32'(out_of(k)), 32'h0);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef DEMUX_RR_EN
    // Round robin, all consumers ready, in_sel held at 3.
    add(0, 1, 3, 8'h10, 4'b1111, 1, 4'b0001, 1, 0, 8'h10);
    add(0, 1, 3, 8'h20, 4'b1111, 1, 4'b0010, 1, 1, 8'h20);
    add(0, 1, 3, 8'h30, 4'b1111, 1, 4'b0100, 1, 2, 8'h30);
    add(0, 1, 3, 8'h40, 4'b1111, 1, 4'b1000, 1, 3, 8'h40);
    add(0, 1, 3, 8'h50, 4'b1111, 1, 4'b0001, 1, 0, 8'h50);
    add(1, 0, 3, 8'h00, 4'b0000, 1, 4'b0000, 0, 0, 8'h00);
    // Channel b stalled: the sixth word waits for b and the pointer holds at 1.
    add(0, 1, 3, 8'h10, 4'b1101, 1, 4'b0001, 1, 0, 8'h10);
    add(0, 1, 3, 8'h20, 4'b1101, 1, 4'b0010, 1, 1, 8'h20);
    add(0, 1, 3, 8'h30, 4'b1101, 1, 4'b0110, 1, 2, 8'h30);
    add(0, 1, 3, 8'h40, 4'b1101, 1, 4'b1010, 1, 3, 8'h40);
    add(0, 1, 3, 8'h50, 4'b1101, 1, 4'b0011, 1, 0, 8'h50);
    add(0, 1, 3, 8'h60, 4'b1101, 0, 4'b0010, 1, 1, 8'h20);
    add(0, 1, 3, 8'h60, 4'b1101, 0, 4'b0010, 1, 1, 8'h20);
    add(0, 1, 3, 8'h60, 4'b1111, 1, 4'b0010, 1, 1, 8'h60);
    add(0, 0, 3, 8'h00, 4'b1111, 1, 4'b0000, 0, 0, 8'h00);
`else
    // Backpressure on c, then independence of a stalled b from a and d.
    add(0, 1, 2, 8'h5A, 4'b0000, 1, 4'b0100, 1, 2, 8'h5A);
    add(0, 1, 2, 8'h11, 4'b0000, 0, 4'b0100, 1, 2, 8'h5A);
    add(0, 1, 2, 8'h11, 4'b0100, 1, 4'b0100, 1, 2, 8'h11);
    add(0, 1, 1, 8'hB1, 4'b0100, 1, 4'b0010, 1, 1, 8'hB1);
    add(0, 1, 0, 8'hA0, 4'b0000, 1, 4'b0011, 1, 1, 8'hB1);
    add(0, 1, 3, 8'hB0, 4'b0000, 1, 4'b1011, 1, 1, 8'hB1);
    add(0, 1, 1, 8'hCC, 4'b0000, 0, 4'b1011, 1, 1, 8'hB1);
    add(0, 1, 1, 8'hCC, 4'b0010, 1, 4'b1011, 1, 1, 8'hCC);
    add(0, 0, 0, 8'h00, 4'b1111, 1, 4'b0000, 0, 0, 8'h00);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n     = ~vecs[i].rst;
      in_valid  = vecs[i].valid;
      in_sel    = vecs[i].sel;
      in_data   = vecs[i].data;
      out_ready = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      if (vecs[i].chk)
        check($sformatf("v%0d_out_ch%0d", i, vecs[i].chk_ch), 32'(out_of(int'(vecs[i].chk_ch))),
              32'(vecs[i].chk_data));
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;

`ifndef DEMUX_RR_EN
    // Streaming at one word per cycle into always-ready consumers.
    out_ready = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'(i % 4);
      in_data  = 8'(i);
      @(negedge clk);
      check($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("stream%0d_valid", i), 32'(out_valid[i % 4]), 32'd1);
      check($sformatf("stream%0d_data", i), 32'(out_of(i % 4)), 32'(i));
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("stream_idle_valid", 32'(out_valid), 32'h0);
`endif

    // Reset mid-operation with two stalled entries.
`ifdef DEMUX_RR_EN
    exp_two = 4'b0011;
    exp_one = 4'b0001;
`else
    exp_two = 4'b1001;
    exp_one = 4'b0010;
`endif
    out_ready = 4'b0000;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_sel   = 2'd0;
    in_data  = 8'hE0;
    @(posedge clk);
    #1;
    in_sel  = 2'd3;
    in_data = 8'hE3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("midrst_loaded", 32'(out_valid), 32'(exp_two));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_valid", 32'(out_valid), 32'h0);
    for (int k = 0; k < 4; k++) check($sformatf("midrst_out%0d", k), 32'(out_of(k)), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("postrst_idle%0d", i), 32'(out_valid), 32'h0);
    end

    // First transfer after reset, then a full drain.
    in_valid = 1'b1;
    in_sel   = 2'd1;
    in_data  = 8'h77;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("postrst_load", 32'(out_valid), 32'(exp_one));
    out_ready = 4'b1111;
    @(posedge clk);
    #1;
    check("final_drain_valid", 32'(out_valid), 32'h0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
